// File: rtl/clock_monitor_if.sv
// Signal bundle between a monitored-clock source and the clock_monitor block.
// The source side drives mon_clk/clear; the monitor side drives the measurement results.
interface clock_monitor_if #(
  parameter int CNT_W = 16
);
  logic             mon_clk;
  logic             clear;
  logic             meas_valid;
  logic [CNT_W-1:0] period_cycles;
  logic [CNT_W-1:0] high_cycles;
  logic             freq_err;
  logic             locked;
  logic             clk_present;
  logic             stop_evt;

  modport master (
    output mon_clk, clear,
    input  meas_valid, period_cycles, high_cycles, freq_err, locked, clk_present, stop_evt
  );

  modport slave (
    input  mon_clk, clear,
    output meas_valid, period_cycles, high_cycles, freq_err, locked, clk_present, stop_evt
  );
endinterface

// File: rtl/clock_monitor.sv
// Samples an asynchronous clock as data in the clk domain and reports its period, high
// time, frequency error, lock and stopped-clock status.
//
//   state   | meaning
//   ACQUIRE | waiting for the first rise; partial period is discarded
//   ARM     | counting the first full period, no frequency check yet
//   TRACK   | measuring every period, checking it against EXP_PERIOD
//   STOPPED | no edge for TIMEOUT cycles; next rise re-arms
module clock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int EXP_PERIOD  = 10,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic           clk,
  input  logic           async_reset_n,
  clock_monitor_if.slave bus
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ACQUIRE, ARM, TRACK, STOPPED} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_prev;
  logic                   rise;
  logic                   fall;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hcnt;
  logic [IDLE_W-1:0]      idle;
  logic [GOOD_W-1:0]      good;

  logic [CNT_W:0]         cnt_x;
  logic [CNT_W:0]         diff;
  logic                   period_bad;
  logic                   timeout_hit;
  logic                   take_meas;
  logic                   do_check;
  logic                   stop_go;

  logic                   meas_valid_r;
  logic [CNT_W-1:0]       period_r;
  logic [CNT_W-1:0]       high_r;
  logic                   freq_err_r;
  logic                   locked_r;
  logic                   clk_present_r;
  logic                   stop_evt_r;

  // Edge pulses are registered, so the measurement lands SYNC_STAGES+2 cycles after the input edge
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync   <= '0;
      s_prev <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], bus.mon_clk};
      s_prev <= sync[SYNC_STAGES-1];
      rise   <= sync[SYNC_STAGES-1] & ~s_prev;
      fall   <= ~sync[SYNC_STAGES-1] & s_prev;
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      cnt  <= '0;
      hcnt <= '0;
      idle <= '0;
    end else begin
      if (rise)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);

      if (fall && (state == ARM || state == TRACK))
        hcnt <= cnt;

      if (rise || fall)
        idle <= '0;
      else if (idle != IDLE_W'(TIMEOUT))
        idle <= idle + IDLE_W'(1);
    end
  end

  // Difference taken one bit wider than cnt so it never wraps
  always_comb begin
    cnt_x      = {1'b0, cnt};
    diff       = (cnt_x >= (CNT_W+1)'(EXP_PERIOD)) ? cnt_x - (CNT_W+1)'(EXP_PERIOD)
                                                   : (CNT_W+1)'(EXP_PERIOD) - cnt_x;
    period_bad = (cnt == CNT_MAX) || (diff > (CNT_W+1)'(TOL));
  end

  assign timeout_hit = !rise && !fall && (idle >= IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n)
      state <= ACQUIRE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_meas  = 1'b0;
    do_check   = 1'b0;
    stop_go    = 1'b0;
    if (bus.clear) begin
      state_next = ACQUIRE;
    end else if (timeout_hit && state != STOPPED) begin
      state_next = STOPPED;
      stop_go    = 1'b1;
    end else if (rise) begin
      case (state)
        ACQUIRE: state_next = ARM;
        ARM: begin
          state_next = TRACK;
          take_meas  = 1'b1;
        end
        TRACK: begin
          take_meas = 1'b1;
          do_check  = 1'b1;
        end
        STOPPED: state_next = ARM;
        default: state_next = ACQUIRE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      meas_valid_r  <= 1'b0;
      period_r      <= '0;
      high_r        <= '0;
      freq_err_r    <= 1'b0;
      locked_r      <= 1'b0;
      clk_present_r <= 1'b0;
      stop_evt_r    <= 1'b0;
      good          <= '0;
    end else begin
      meas_valid_r <= take_meas;
      freq_err_r   <= do_check && period_bad;
      stop_evt_r   <= stop_go && clk_present_r;

      if (take_meas) begin
        period_r <= cnt;
        high_r   <= hcnt;
      end

      if (stop_go)
        clk_present_r <= 1'b0;
      else if (rise)
        clk_present_r <= 1'b1;

      if (bus.clear || stop_go) begin
        good     <= '0;
        locked_r <= 1'b0;
      end else if (do_check) begin
        if (period_bad) begin
          good     <= '0;
          locked_r <= 1'b0;
        end else begin
          if (good != GOOD_W'(LOCK_COUNT))
            good <= good + GOOD_W'(1);
          locked_r <= (good >= GOOD_W'(LOCK_COUNT - 1));
        end
      end
    end
  end

  assign bus.meas_valid    = meas_valid_r;
  assign bus.period_cycles = period_r;
  assign bus.high_cycles   = high_r;
  assign bus.freq_err      = freq_err_r;
  assign bus.locked        = locked_r;
  assign bus.clk_present   = clk_present_r;
  assign bus.stop_evt      = stop_evt_r;

endmodule
